// File: rtl/ddr4_cmd_monitor.sv
// ddr4_cmd_monitor
//   Passive DDR4 command-bus monitor. It samples the same command/address pins
//   the DIMM sees, decodes one command per clock, tracks open/closed state and
//   a tRCD/tRP timer for each of the 16 banks, flags protocol violations and
//   keeps saturating ACT/RD/WR counters.
// Ports
//   sys_clk, sys_reset         rising-edge clock, synchronous active-high reset
//   c0_ddr4_act_n/adr/ba/bg    command/address taps (inputs only)
//   c0_ddr4_cs_n/cke           a command is sampled only when cs_n=0 and cke=1
//   cmd_valid/type/bank/...    registered decode, one cycle after the sample edge
//   bank_open                  bit k set while bank {bg,ba}=k is open
//   err_valid/err_code         violation pulse aligned with cmd_valid
//   err_sticky                 set on any violation until reset
//   act_cnt/rd_cnt/wr_cnt      saturating command counts

// Per-bank state: open flag plus one shared timer. Which delay the timer is
// currently enforcing (tRCD or tRP) is implied by the open flag.
module ddr4_bank_state #(
    parameter int T_RCD = 16,
    parameter int T_RP  = 16,
    parameter int TW    = 4
) (
    input  logic sys_clk,
    input  logic sys_reset,
    input  logic act,
    input  logic close,
    output logic is_open,
    output logic timer_zero
);
    logic [TW-1:0] tmr;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            is_open <= 1'b0;
            tmr     <= '0;
        end else if (act) begin
            is_open <= 1'b1;
            tmr     <= TW'(T_RCD - 1);
        end else if (close) begin
            is_open <= 1'b0;
            tmr     <= TW'(T_RP - 1);
        end else if (tmr != '0) begin
            tmr     <= tmr - 1'b1;
        end
    end

    assign timer_zero = (tmr == '0);
endmodule

module ddr4_cmd_monitor #(
    parameter int T_RCD = 16,
    parameter int T_RP  = 16,
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             c0_ddr4_act_n,
    input  logic [16:0]      c0_ddr4_adr,
    input  logic [1:0]       c0_ddr4_ba,
    input  logic [1:0]       c0_ddr4_bg,
    input  logic             c0_ddr4_cs_n,
    input  logic             c0_ddr4_cke,
    output logic             cmd_valid,
    output logic [3:0]       cmd_type,
    output logic [3:0]       cmd_bank,
    output logic [16:0]      cmd_row,
    output logic [9:0]       cmd_col,
    output logic             cmd_ap,
    output logic [15:0]      bank_open,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] act_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);
    localparam int NUM_BANKS = 16;
    localparam int TMAX      = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TW        = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

    localparam logic [3:0] C_MRS = 4'd0, C_REF = 4'd1, C_PRE = 4'd2, C_PREA = 4'd3,
                           C_WR  = 4'd4, C_RD  = 4'd5, C_ZQC = 4'd6, C_ACT  = 4'd7,
                           C_RFU = 4'd8;

    logic                 sample, valid_d;
    logic [3:0]           type_d, sel;
    logic [2:0]           err_d;
    logic                 is_act, is_rd, is_wr, is_pre, is_prea, is_ref;
    logic [NUM_BANKS-1:0] open_v, tz_v;

    assign sample = !c0_ddr4_cs_n && c0_ddr4_cke;
    assign sel    = {c0_ddr4_bg, c0_ddr4_ba};

    always_comb begin
        valid_d = 1'b0;
        type_d  = C_MRS;
        if (sample) begin
            valid_d = 1'b1;
            if (!c0_ddr4_act_n) begin
                type_d = C_ACT;
            end else begin
                case (c0_ddr4_adr[16:14])
                    3'b000:  type_d = C_MRS;
                    3'b001:  type_d = C_REF;
                    3'b010:  type_d = c0_ddr4_adr[10] ? C_PREA : C_PRE;
                    3'b011:  type_d = C_RFU;
                    3'b100:  type_d = C_WR;
                    3'b101:  type_d = C_RD;
                    3'b110:  type_d = C_ZQC;
                    default: valid_d = 1'b0;   // 111 is a NOP
                endcase
            end
        end
    end

    assign is_act  = valid_d && (type_d == C_ACT);
    assign is_rd   = valid_d && (type_d == C_RD);
    assign is_wr   = valid_d && (type_d == C_WR);
    assign is_pre  = valid_d && (type_d == C_PRE);
    assign is_prea = valid_d && (type_d == C_PREA);
    assign is_ref  = valid_d && (type_d == C_REF);

    genvar k;
    generate
        for (k = 0; k < NUM_BANKS; k++) begin : g_bank
            logic hit;
            assign hit = (sel == 4'(k));
            ddr4_bank_state #(.T_RCD(T_RCD), .T_RP(T_RP), .TW(TW)) u_bank (
                .sys_clk    (sys_clk),
                .sys_reset  (sys_reset),
                .act        (is_act && hit),
                // auto-precharge closes the addressed bank on the RD/WR edge
                .close      (is_prea || (hit && (is_pre ||
                             ((is_rd || is_wr) && c0_ddr4_adr[10])))),
                .is_open    (open_v[k]),
                .timer_zero (tz_v[k])
            );
        end
    endgenerate

    // Closed-bank and open-bank errors take priority over the timer errors.
    always_comb begin
        err_d = 3'd0;
        if (is_rd || is_wr) begin
            if (!open_v[sel])   err_d = 3'd1;
            else if (!tz_v[sel]) err_d = 3'd3;
        end else if (is_act) begin
            if (open_v[sel])    err_d = 3'd2;
            else if (!tz_v[sel]) err_d = 3'd4;
        end else if (is_ref) begin
            if (|open_v)        err_d = 3'd5;
        end else if (valid_d && (type_d == C_RFU)) begin
            err_d = 3'd6;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            cmd_valid  <= 1'b0;
            cmd_type   <= '0;
            cmd_bank   <= '0;
            cmd_row    <= '0;
            cmd_col    <= '0;
            cmd_ap     <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= '0;
            err_sticky <= 1'b0;
            act_cnt    <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
        end else begin
            cmd_valid  <= valid_d;
            cmd_type   <= valid_d ? type_d : 4'd0;
            cmd_bank   <= valid_d ? sel : 4'd0;
            cmd_row    <= is_act ? c0_ddr4_adr : 17'd0;
            cmd_col    <= (is_rd || is_wr) ? c0_ddr4_adr[9:0] : 10'd0;
            cmd_ap     <= (is_rd || is_wr) && c0_ddr4_adr[10];
            err_valid  <= (err_d != 3'd0);
            err_code   <= err_d;
            if (err_d != 3'd0) err_sticky <= 1'b1;
            if (is_act && (act_cnt != '1)) act_cnt <= act_cnt + 1'b1;
            if (is_rd  && (rd_cnt  != '1)) rd_cnt  <= rd_cnt  + 1'b1;
            if (is_wr  && (wr_cnt  != '1)) wr_cnt  <= wr_cnt  + 1'b1;
        end
    end

    assign bank_open = open_v;
endmodule

// File: tb/tb_ddr4_cmd_monitor.sv
// Scoreboard bench for ddr4_cmd_monitor. Each driven cycle pushes the expected
// decode; the monitor pops one entry per clock after the DUT's output edge.
// Counters are built 3 bits wide so saturation is reachable quickly.
module tb_ddr4_cmd_monitor;
    localparam int CW = 3;

    logic          clk = 1'b0, rst = 1'b0;
    logic          act_n = 1'b1, cs_n = 1'b1, cke = 1'b1;
    logic [16:0]   adr = '0;
    logic [1:0]    ba = '0, bg = '0;
    logic          cmd_valid, cmd_ap, err_valid, err_sticky;
    logic [3:0]    cmd_type, cmd_bank;
    logic [16:0]   cmd_row;
    logic [9:0]    cmd_col;
    logic [15:0]   bank_open;
    logic [2:0]    err_code;
    logic [CW-1:0] act_cnt, rd_cnt, wr_cnt;

    int checks = 0, errors = 0;

    typedef struct {
        logic        v;
        logic [3:0]  typ;
        logic [3:0]  bank;
        logic [16:0] row;
        logic [9:0]  col;
        logic        ap;
        logic [2:0]  ec;
    } exp_t;
    exp_t sb[$];

    ddr4_cmd_monitor #(.T_RCD(16), .T_RP(16), .CNT_W(CW)) dut (
        .sys_clk(clk), .sys_reset(rst),
        .c0_ddr4_act_n(act_n), .c0_ddr4_adr(adr), .c0_ddr4_ba(ba), .c0_ddr4_bg(bg),
        .c0_ddr4_cs_n(cs_n), .c0_ddr4_cke(cke),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ap(cmd_ap),
        .bank_open(bank_open), .err_valid(err_valid), .err_code(err_code),
        .err_sticky(err_sticky), .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("cmd_valid", 32'(cmd_valid), 32'(e.v));
            chk("err_valid", 32'(err_valid), 32'(e.ec != 3'd0));
            if (e.ec != 3'd0) chk("err_code", 32'(err_code), 32'(e.ec));
            if (e.v) begin
                chk("cmd_type", 32'(cmd_type), 32'(e.typ));
                chk("cmd_bank", 32'(cmd_bank), 32'(e.bank));
                chk("cmd_row",  32'(cmd_row),  32'(e.row));
                chk("cmd_col",  32'(cmd_col),  32'(e.col));
                chk("cmd_ap",   32'(cmd_ap),   32'(e.ap));
            end
        end
    end

    task automatic drive(input logic r, input logic c_n, input logic ck, input logic a_n,
                         input logic [16:0] ad, input logic [3:0] bk, input exp_t e);
        @(negedge clk);
        rst = r; cs_n = c_n; cke = ck; act_n = a_n; adr = ad;
        bg = bk[3:2]; ba = bk[1:0];
        sb.push_back(e);
    endtask

    function automatic exp_t mk(input logic v, input logic [3:0] t, input logic [3:0] b,
                                input logic [16:0] r, input logic [9:0] c, input logic ap,
                                input logic [2:0] ec);
        exp_t e;
        e.v = v; e.typ = t; e.bank = b; e.row = r; e.col = c; e.ap = ap; e.ec = ec;
        return e;
    endfunction

    task automatic nop(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b1, 1'b1, 17'h1FFFF, 4'd0, mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic reset_cyc();
        // a command on the bus during reset must be ignored
        drive(1'b1, 1'b0, 1'b1, 1'b0, 17'h00055, 4'd1, mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic act(input logic [3:0] b, input logic [16:0] row, input logic [2:0] ec);
        drive(1'b0, 1'b0, 1'b1, 1'b0, row, b, mk(1, 7, b, row, 0, 0, ec));
    endtask

    task automatic rdwr(input logic rd, input logic [3:0] b, input logic [9:0] col,
                        input logic ap, input logic [2:0] ec);
        logic [16:0] a;
        a = {rd ? 3'b101 : 3'b100, 3'b000, ap, col};
        drive(1'b0, 1'b0, 1'b1, 1'b1, a, b, mk(1, rd ? 4'd5 : 4'd4, b, 0, col, ap, ec));
    endtask

    task automatic other(input logic [16:0] a, input logic [3:0] t, input logic [2:0] ec);
        drive(1'b0, 1'b0, 1'b1, 1'b1, a, 4'd0, mk(1, t, 0, 0, 0, 0, ec));
    endtask

    // sample the register state just after the command's output edge
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_cyc();
        settle();
        chk("rst_open", 32'(bank_open), 0);
        chk("rst_sticky", 32'(err_sticky), 0);
        chk("rst_act", 32'(act_cnt), 0);

        // ACT then RD exactly tRCD later
        act(4'd6, 17'h1ABCD, 0);
        nop(15);
        rdwr(1, 4'd6, 10'h3F0, 0, 0);
        settle();
        chk("s1_open", 32'(bank_open), 32'h0040);
        chk("s1_rd", 32'(rd_cnt), 1);
        chk("s1_sticky", 32'(err_sticky), 0);

        // RD one clock early
        act(4'd0, 17'h00123, 0);
        nop(14);
        rdwr(1, 4'd0, 10'h010, 0, 3);
        settle();
        chk("s2_sticky", 32'(err_sticky), 1);
        chk("s2_act", 32'(act_cnt), 2);

        // WR to a closed bank
        rdwr(0, 4'd5, 10'h155, 0, 1);
        settle();
        chk("s3_wr", 32'(wr_cnt), 1);
        chk("s3_open", 32'(bank_open), 32'h0041);

        // reset mid-stream
        reset_cyc();
        settle();
        chk("mid_open", 32'(bank_open), 0);
        chk("mid_sticky", 32'(err_sticky), 0);
        chk("mid_rd", 32'(rd_cnt), 0);
        chk("mid_wr", 32'(wr_cnt), 0);
        chk("mid_valid", 32'(cmd_valid), 0);

        // PREA then ACT at +15 (tRP) and +16 (already open)
        act(4'd0, 17'h00001, 0);
        act(4'd3, 17'h00002, 0);
        act(4'd15, 17'h00003, 0);
        settle();
        chk("s4_open3", 32'(bank_open), 32'h8009);
        other(17'h0A400, 4'd3, 0);
        nop(14);
        act(4'd3, 17'h00004, 4);
        act(4'd3, 17'h00005, 2);
        settle();
        chk("s4_open", 32'(bank_open), 32'h0008);
        chk("s4_act", 32'(act_cnt), 5);

        // auto-precharge, then REF with and without open banks
        reset_cyc();
        act(4'd2, 17'h00010, 0);
        nop(15);
        rdwr(1, 4'd2, 10'h020, 1, 0);
        settle();
        chk("s5_ap_open", 32'(bank_open), 0);
        other(17'h04000, 4'd1, 0);
        nop(15);
        act(4'd2, 17'h00011, 0);
        nop(15);
        rdwr(1, 4'd2, 10'h021, 0, 0);
        other(17'h04000, 4'd1, 5);
        settle();
        chk("s5_open", 32'(bank_open), 32'h0004);

        // MRS, ZQC, RFU encodings
        other(17'h00000, 4'd0, 0);
        other(17'h18000, 4'd6, 0);
        other(17'h0C000, 4'd8, 6);

        // deselected and clock-disabled cycles are NOPs
        drive(1'b0, 1'b1, 1'b1, 1'b1, 17'h14000, 4'd2, mk(0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 1'b0, 1'b0, 1'b1, 17'h14000, 4'd2, mk(0, 0, 0, 0, 0, 0, 0));
        settle();
        chk("s6_rd", 32'(rd_cnt), 2);

        // counter saturation
        repeat (9) rdwr(0, 4'd9, 10'h001, 0, 1);
        settle();
        chk("sat_wr", 32'(wr_cnt), 32'h7);

        nop(1);
        repeat (4) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
